// File: rtl/pdm_cfg_spi_ctrl_pkg.sv
// Shared constants and types for the PDM config SPI controller.
package pdm_cfg_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam logic [ADDR_W-1:0] COMMIT_ADDR_DEF = 8'hFF;

  // Register map of the pitch-filter datapath
  localparam int REG_DECIM    = 0;
  localparam int REG_PITCH_LO = 1;
  localparam int REG_PITCH_HI = 2;
  localparam int REG_GAIN     = 3;

  // One received frame: address byte first, then data byte
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_frame_t;

  function automatic logic addr_is_reg(input logic [ADDR_W-1:0] a, input int num_regs);
    return int'(a) < num_regs;
  endfunction
endpackage

// File: rtl/pdm_cfg_spi_ctrl_if.sv
// Pin-side and datapath-side signals of the config controller.
interface pdm_cfg_spi_ctrl_if #(
  parameter int NUM_REGS = 8
);
  logic                  spi_mosi;
  logic                  spi_cs_n;
  logic                  frame_sync;
  logic [NUM_REGS*8-1:0] cfg_active;
  logic                  cfg_update;
  logic                  commit_pending;
  logic                  err_addr;
  logic                  err_abort;

  modport master (
    output spi_mosi, spi_cs_n, frame_sync,
    input  cfg_active, cfg_update, commit_pending, err_addr, err_abort
  );

  modport slave (
    input  spi_mosi, spi_cs_n, frame_sync,
    output cfg_active, cfg_update, commit_pending, err_addr, err_abort
  );
endinterface

// File: rtl/pdm_cfg_spi_rx.sv
// Serial frame receiver: 16-bit MSB-first shift, bit count, abort detect.
module pdm_cfg_spi_rx
  import pdm_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       frame_valid,
  output cfg_frame_t frame,
  output logic       abort
);
  logic [FRAME_BITS-1:0] shift_reg;
  logic [3:0]            bit_cnt;

  // Shift while selected; a full 16 bits flags a frame, an early deselect flags an abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      abort       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      abort       <= 1'b0;
      if (!spi_cs_n) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], spi_mosi};
        bit_cnt   <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) frame_valid <= 1'b1;
      end else if (bit_cnt != 4'd0) begin
        bit_cnt <= '0;
        abort   <= 1'b1;
      end
    end
  end

  // Held until the next shift, so the parent sees the whole frame on the decode edge
  assign frame = cfg_frame_t'(shift_reg);
endmodule

// File: rtl/pdm_cfg_spi_ctrl.sv
// Config controller: shadow bank written over SPI, copied to the active
// bank on frame_sync once a commit has been received.
module pdm_cfg_spi_ctrl
  import pdm_cfg_pkg::*;
#(
  parameter int                    NUM_REGS    = 8,
  parameter logic [NUM_REGS*8-1:0] RESET_CFG   = '0,
  parameter logic [ADDR_W-1:0]     COMMIT_ADDR = COMMIT_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pdm_cfg_spi_ctrl_if.slave    bus
);
  logic                             frame_valid;
  logic                             abort;
  cfg_frame_t                       frame;
  logic [NUM_REGS-1:0][DATA_W-1:0]  shadow;
  logic [NUM_REGS-1:0][DATA_W-1:0]  active;
  logic                             pending;
  logic                             update;
  logic                             err_addr;
  logic                             is_reg;
  logic                             is_commit;

  pdm_cfg_spi_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .spi_mosi    (bus.spi_mosi),
    .spi_cs_n    (bus.spi_cs_n),
    .frame_valid (frame_valid),
    .frame       (frame),
    .abort       (abort)
  );

  assign is_reg    = addr_is_reg(frame.addr, NUM_REGS);
  assign is_commit = frame.addr == COMMIT_ADDR;

  // Shadow writes from decoded register frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= RESET_CFG;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (frame_valid && frame.addr == 8'(i)) shadow[i] <= frame.data;
    end
  end

  // Commit handshake: copy uses pre-edge shadow and pending, so a commit or
  // write decoded on the sync edge waits for the next sync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= RESET_CFG;
      pending  <= 1'b0;
      update   <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      update   <= 1'b0;
      err_addr <= 1'b0;
      if (pending && bus.frame_sync) begin
        active  <= shadow;
        update  <= 1'b1;
        pending <= 1'b0;
      end
      if (frame_valid && !is_reg) begin
        if (is_commit) pending  <= 1'b1;
        else           err_addr <= 1'b1;
      end
    end
  end

  assign bus.cfg_active     = active;
  assign bus.cfg_update     = update;
  assign bus.commit_pending = pending;
  assign bus.err_addr       = err_addr;
  assign bus.err_abort      = abort;
endmodule

// File: tb/tb_pdm_cfg_spi_ctrl.sv
// Bench for pdm_cfg_spi_ctrl: directed plan plus random traffic, checked
// against a frame-level model with pulse scoreboards.
module tb_pdm_cfg_spi_ctrl;
  import pdm_cfg_pkg::*;

  localparam int NR = 8;
  localparam logic [NR*8-1:0] RCFG = 64'hA1B2_C3D4_E5F6_0718;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pdm_cfg_spi_ctrl_if #(.NUM_REGS(NR)) bus();

  pdm_cfg_spi_ctrl #(
    .NUM_REGS    (NR),
    .RESET_CFG   (RCFG),
    .COMMIT_ADDR (8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_shadow [NR];
  logic [7:0]  m_active [NR];
  bit          m_pend;
  int          nbits;
  logic [15:0] fbits;
  bit          dec_next;
  logic [15:0] dec_frame;
  int          cyc = 0;
  bit          fs_rand = 0;
  logic [NR*8-1:0] rcfg_v = RCFG;

  typedef struct { int cyc; logic [NR*8-1:0] cfg; } upd_t;
  upd_t upd_q[$];
  int   addr_q[$];
  int   abort_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [NR*8-1:0] pack_active();
    logic [NR*8-1:0] v;
    for (int i = 0; i < NR; i++) v[i*8 +: 8] = m_active[i];
    return v;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void miss(input string nm, input int c);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: pulse expected at cycle %0d not seen (now %0d)", nm, c, cyc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = rcfg_v[i*8 +: 8];
      m_active[i] = rcfg_v[i*8 +: 8];
    end
    m_pend = 0; nbits = 0; fbits = '0; dec_next = 0; dec_frame = '0;
    upd_q.delete(); addr_q.delete(); abort_q.delete();
  endtask

  // One clock: drive inputs at the negedge, advance the model by one edge
  task automatic tick(input bit r, input bit mosi, input bit cs_n, input bit fs);
    bit fsx;
    logic [7:0] a;
    fsx = fs | (fs_rand && $urandom_range(7) == 0);
    rst = r; bus.spi_mosi = mosi; bus.spi_cs_n = cs_n; bus.frame_sync = fsx;
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      if (m_pend && fsx) begin
        for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
        m_pend = 0;
        upd_q.push_back('{cyc, pack_active()});
      end
      if (dec_next) begin
        a = dec_frame[15:8];
        if (int'(a) < NR) m_shadow[a] = dec_frame[7:0];
        else if (a == 8'hFF) m_pend = 1;
        else addr_q.push_back(cyc);
      end
      dec_next = 0;
      if (!cs_n) begin
        fbits = {fbits[14:0], mosi};
        nbits++;
        if (nbits == 16) begin dec_next = 1; dec_frame = fbits; nbits = 0; end
      end else if (nbits != 0) begin
        abort_q.push_back(cyc);
        nbits = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] f, input int nb);
    for (int i = 15; i > 15 - nb; i--) tick(0, f[i], 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0);
  endtask

  task automatic sync();
    tick(0, 0, 1, 1);
  endtask

  // Monitor: 2 time units after each edge, compare state and pop pulse scoreboards
  initial begin
    upd_t u;
    int   c;
    forever begin
      @(posedge clk);
      #2;
      chk("cfg_active", 64'(bus.cfg_active), 64'(pack_active()));
      chk("commit_pending", 64'(bus.commit_pending), 64'(m_pend));
      while (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin c = upd_q[0].cyc; void'(upd_q.pop_front()); miss("cfg_update", c); end
      while (addr_q.size() > 0 && addr_q[0] < cyc) begin miss("err_addr", addr_q.pop_front()); end
      while (abort_q.size() > 0 && abort_q[0] < cyc) begin miss("err_abort", abort_q.pop_front()); end
      if (bus.cfg_update) begin
        if (upd_q.size() == 0) chk("cfg_update_unexpected", 64'(bus.cfg_update), 64'd0);
        else begin
          u = upd_q.pop_front();
          chk("cfg_update_cycle", 64'(cyc), 64'(u.cyc));
          chk("cfg_update_value", 64'(bus.cfg_active), 64'(u.cfg));
        end
      end
      if (bus.err_addr) begin
        if (addr_q.size() == 0) chk("err_addr_unexpected", 64'(bus.err_addr), 64'd0);
        else chk("err_addr_cycle", 64'(cyc), 64'(addr_q.pop_front()));
      end
      if (bus.err_abort) begin
        if (abort_q.size() == 0) chk("err_abort_unexpected", 64'(bus.err_abort), 64'd0);
        else chk("err_abort_cycle", 64'(cyc), 64'(abort_q.pop_front()));
      end
    end
  end

  initial begin
    bus.spi_mosi = 0; bus.spi_cs_n = 1; bus.frame_sync = 0;
    model_reset();

    // 1: reset values
    tick(1, 0, 1, 0); tick(1, 0, 1, 0);
    idle(16);
    chk("reset_cfg", 64'(bus.cfg_active), 64'(rcfg_v));
    chk("reset_flags", 64'({bus.cfg_update, bus.commit_pending, bus.err_addr, bus.err_abort}), 64'd0);

    // 2: write then commit
    send(16'h025A, 16);
    send(16'hFF00, 16);
    idle(10);
    chk("pre_sync_cfg", 64'(bus.cfg_active), 64'(rcfg_v));
    chk("pre_sync_pending", 64'(bus.commit_pending), 64'd1);
    sync();
    chk("post_sync_byte2", 64'(bus.cfg_active[23:16]), 64'h5A);
    chk("post_sync_update", 64'(bus.cfg_update), 64'd1);
    chk("post_sync_pending", 64'(bus.commit_pending), 64'd0);
    idle(3);

    // 3: aborted frame leaves reg 3 alone
    send(16'h0377, 9);
    idle(3);
    send(16'hFF00, 16);
    idle(2); sync(); idle(2);
    chk("abort_reg3", 64'(bus.cfg_active[31:24]), 64'(rcfg_v[31:24]));

    // 4: bad address then a good one, back to back
    send(16'h0911, 16);
    send(16'h0122, 16);
    idle(2);
    send(16'hFF00, 16);
    idle(2); sync(); idle(2);
    chk("b2b_reg1", 64'(bus.cfg_active[15:8]), 64'h22);

    // 5a: sync on the commit decode edge is too early
    send(16'h0433, 16);
    send(16'hFF00, 16);
    sync();
    chk("early_sync_pending", 64'(bus.commit_pending), 64'd1);
    chk("early_sync_reg4", 64'(bus.cfg_active[39:32]), 64'(rcfg_v[39:32]));
    idle(3); sync(); idle(1);
    chk("late_sync_reg4", 64'(bus.cfg_active[39:32]), 64'h33);

    // 5b: shadow write decoded on the copy edge lands in shadow only
    send(16'hFF00, 16);
    idle(2);
    send(16'h0566, 16);
    sync();
    chk("collide_reg5_old", 64'(bus.cfg_active[47:40]), 64'(rcfg_v[47:40]));
    send(16'hFF00, 16);
    idle(2); sync(); idle(1);
    chk("collide_reg5_new", 64'(bus.cfg_active[47:40]), 64'h66);

    // 6: reset mid-frame with a commit pending
    send(16'hFF00, 16);
    idle(2);
    send(16'h0699, 8);
    tick(1, 0, 1, 0); tick(1, 0, 1, 0);
    chk("rst_mid_pending", 64'(bus.commit_pending), 64'd0);
    chk("rst_mid_cfg", 64'(bus.cfg_active), 64'(rcfg_v));
    idle(2);
    send(16'h0677, 16);
    send(16'hFF00, 16);
    idle(2); sync(); idle(1);
    chk("after_rst_reg6", 64'(bus.cfg_active[55:48]), 64'h77);

    // Random traffic with random frame_sync
    fs_rand = 1;
    for (int k = 0; k < 400; k++) begin
      logic [15:0] f;
      int sel;
      sel = $urandom_range(0, 9);
      f[7:0] = 8'($urandom);
      if (sel < 8)       f[15:8] = 8'(sel);
      else if (sel == 8) f[15:8] = 8'hFF;
      else               f[15:8] = 8'($urandom_range(8, 254));
      if ($urandom_range(9) == 0) send(f, $urandom_range(1, 15));
      else                        send(f, 16);
      idle($urandom_range(0, 3));
    end
    fs_rand = 0;
    idle(4); sync(); idle(4);

    chk("leftover_pulses", 64'(upd_q.size() + addr_q.size() + abort_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
